// File: rtl/tube_0c_arbiter.sv
// ---------------------------------------------------------------------------
// tube_0c_arbiter
//
// Purpose:
//   Shares one combinational tube_0c ALU between NUM_REQ requesters. Each cycle
//   a round-robin arbiter picks one valid requester and steers its operands and
//   op into the ALU. The ALU result is captured in a single-entry response
//   register that uses a valid/ready handshake. Accepted issues are counted.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   req_valid/ready per-requester handshake (ready is one-hot or zero)
//   req_data1/2/op  per-requester operands and op
//   alu_in_*/alu_op steering to the shared ALU (all zero when idle)
//   alu_out_*       result coming back from the ALU in the same cycle
//   rsp_valid/ready response handshake towards the consumer
//   rsp_data/rsp_id registered result and index of the producing requester
//   issue_count     number of accepted operations, wraps
// ---------------------------------------------------------------------------

// Checks that the shared ALU answers in the same cycle it is driven.
module tube_0c_arbiter_chk (
    input  logic clk,
    input  logic rst_n,
    input  logic alu_in_valid,
    input  logic alu_out_valid
);
    a_alu_comb: assert property (@(posedge clk) disable iff (!rst_n)
        alu_out_valid == alu_in_valid);
endmodule

module tube_0c_arbiter #(
    parameter int  REG_WIDTH = 32,
    parameter int  NUM_REQ   = 4,
    parameter type T_tube_op = logic,
    parameter int  CNT_WIDTH = 16,
    localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][REG_WIDTH-1:0]  req_data1,
    input  logic [NUM_REQ-1:0][REG_WIDTH-1:0]  req_data2,
    input  T_tube_op [NUM_REQ-1:0]             req_op,
    output logic                               alu_in_valid,
    output logic [REG_WIDTH-1:0]               alu_in_data1,
    output logic [REG_WIDTH-1:0]               alu_in_data2,
    output T_tube_op                           alu_op,
    input  logic                               alu_out_valid,
    input  logic [REG_WIDTH-1:0]               alu_out_data,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [REG_WIDTH-1:0]               rsp_data,
    output logic [ID_WIDTH-1:0]                rsp_id,
    output logic [CNT_WIDTH-1:0]               issue_count
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [REG_WIDTH-1:0]   r_rsp_data;
    logic [ID_WIDTH-1:0]    r_rsp_id;
    logic [ID_WIDTH-1:0]    r_rr_ptr;
    logic [CNT_WIDTH-1:0]   r_issue_count;

    logic                   w_load;
    logic                   w_grant_any;
    logic [ID_WIDTH-1:0]    w_grant_idx;
    logic [NUM_REQ-1:0]     w_grant;

    // Round-robin search starting at r_rr_ptr; only grants when the response slot can load.
    always_comb begin
        logic [ID_WIDTH:0] v_idx;
        v_idx       = {(ID_WIDTH+1){1'b0}};
        w_load      = (r_state == ST_EMPTY) || rsp_ready;
        w_grant_any = 1'b0;
        w_grant_idx = {ID_WIDTH{1'b0}};
        w_grant     = {NUM_REQ{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            // Wrap the scan index without a general modulo.
            v_idx = {1'b0, r_rr_ptr} + (ID_WIDTH+1)'(k);
            if (v_idx >= (ID_WIDTH+1)'(NUM_REQ)) begin
                v_idx = v_idx - (ID_WIDTH+1)'(NUM_REQ);
            end else begin
                v_idx = v_idx;
            end
            if (w_load && !w_grant_any && req_valid[v_idx[ID_WIDTH-1:0]]) begin
                w_grant_any = 1'b1;
                w_grant_idx = v_idx[ID_WIDTH-1:0];
            end else begin
                w_grant_any = w_grant_any;
            end
        end
        if (w_grant_any) begin
            w_grant[w_grant_idx] = 1'b1;
        end else begin
            w_grant = {NUM_REQ{1'b0}};
        end
    end

    // Steer the granted requester into the ALU; drive zeros when idle so nothing is X.
    always_comb begin
        alu_in_valid = w_grant_any;
        alu_in_data1 = {REG_WIDTH{1'b0}};
        alu_in_data2 = {REG_WIDTH{1'b0}};
        alu_op       = T_tube_op'(1'b0);
        if (w_grant_any) begin
            alu_in_data1 = req_data1[w_grant_idx];
            alu_in_data2 = req_data2[w_grant_idx];
            alu_op       = req_op[w_grant_idx];
        end else begin
            alu_in_valid = 1'b0;
        end
    end

    // Response slot next state: refill (or drain to empty) whenever it can load.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY, ST_FULL: begin
                if (w_load) begin
                    w_state_nxt = alu_out_valid ? ST_FULL : ST_EMPTY;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Response slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Response payload, round-robin pointer and issue counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data    <= {REG_WIDTH{1'b0}};
            r_rsp_id      <= {ID_WIDTH{1'b0}};
            r_rr_ptr      <= {ID_WIDTH{1'b0}};
            r_issue_count <= {CNT_WIDTH{1'b0}};
        end else begin
            if (w_load) begin
                r_rsp_data <= alu_out_data;
                r_rsp_id   <= w_grant_idx;
            end
            if (w_grant_any) begin
                r_rr_ptr      <= (w_grant_idx == ID_WIDTH'(NUM_REQ-1)) ? {ID_WIDTH{1'b0}}
                                                                      : w_grant_idx + {{(ID_WIDTH-1){1'b0}}, 1'b1};
                r_issue_count <= r_issue_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign req_ready   = w_grant;
    assign rsp_valid   = (r_state == ST_FULL);
    assign rsp_data    = r_rsp_data;
    assign rsp_id      = r_rsp_id;
    assign issue_count = r_issue_count;

    tube_0c_arbiter_chk u_chk (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_in_valid (alu_in_valid),
        .alu_out_valid(alu_out_valid)
    );

endmodule
